mult_div_ctrl: RTL

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative multiply/divide controller.
// Multiply is shift-add, divide is restoring division, both one bit per cycle
// over DATA_W iterations, result presented on hi/lo with a one-cycle done pulse.
// Optional feature: define MULT_DIV_SIGNED_EN to treat a/b as two's complement
// (magnitudes are iterated, signs are applied to the final result).
module mult_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_mult,
  input  logic              start_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              MDControl
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] ITER = 6'(DATA_W);

  logic [1:0]        state;
  logic [5:0]        count;
  // work_hi: partial product upper word / partial remainder
  // work_lo: multiplier being shifted out / dividend shifting into quotient
  logic [DATA_W-1:0] work_hi;
  logic [DATA_W-1:0] work_lo;
  logic [DATA_W-1:0] opnd;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_trial;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi;
  logic [DATA_W-1:0] step_lo;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              last_iter;
  logic              div_by_zero;

`ifdef MULT_DIV_SIGNED_EN
  logic sign_a;
  logic sign_b;

  assign a_mag = a[DATA_W-1] ? -a : a;
  assign b_mag = b[DATA_W-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign busy        = (state == S_MULT) || (state == S_DIV);
  assign done        = (state == S_DONE);
  assign last_iter   = (count == 6'd1);
  assign div_by_zero = (opnd == '0);

  // One iteration step of either algorithm plus the final (sign-corrected) result.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path can infer a latch.
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[DATA_W-1]};
    div_trial = div_shift - {1'b0, opnd};
    // Partial remainder is always below the divisor, so the top bit is a clean borrow flag.
    div_ge    = ~div_trial[DATA_W];

    if (state == S_MULT) begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
    end else begin
      step_hi = div_ge ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
      step_lo = {work_lo[DATA_W-2:0], div_ge};
    end

    res_hi = step_hi;
    res_lo = step_lo;
    if (state == S_DIV && div_by_zero) begin
      // Divide by zero: remainder reports the dividend, quotient saturates to all ones.
      res_hi = work_lo;
      res_lo = '1;
    end

`ifdef MULT_DIV_SIGNED_EN
    if (state == S_MULT) begin
      if (sign_a ^ sign_b) {res_hi, res_lo} = -{step_hi, step_lo};
    end else if (div_by_zero) begin
      if (sign_a) res_hi = -work_lo;
    end else begin
      if (sign_a ^ sign_b) res_lo = -step_lo;
      if (sign_a)          res_hi = -step_hi;
    end
`endif
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      // NOTE: the working registers are cleared too, so a discarded operation leaves nothing behind.
      state     <= S_IDLE;
      count     <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      opnd      <= '0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
      MDControl <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mult || start_div) begin
            // start_mult wins a collision; the divide request is dropped.
            state     <= start_mult ? S_MULT : S_DIV;
            MDControl <= ~start_mult;
            div_zero  <= 1'b0;
            count     <= ITER;
            work_hi   <= '0;
            work_lo   <= a_mag;
            opnd      <= b_mag;
`ifdef MULT_DIV_SIGNED_EN
            sign_a    <= a[DATA_W-1];
            sign_b    <= b[DATA_W-1];
`endif
          end
        end

        S_MULT: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          count   <= count - 6'd1;
          if (last_iter) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_DONE;
          end
        end

        S_DIV: begin
          if (div_by_zero) begin
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= 1'b1;
            count    <= '0;
            state    <= S_DONE;
          end else begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            count   <= count - 6'd1;
            if (last_iter) begin
              hi    <= res_hi;
              lo    <= res_lo;
              state <= S_DONE;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
